// File: rtl/prim_dom_rand_pkg.sv
// Shared types and constants for the DOM fresh-randomness generator.
// State codes are pairwise Hamming distance 2 so that a single bit flip never aliases to a legal state.
package prim_dom_rand_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StSeed  = 3'b010,
    StReady = 3'b100
  } state_e;

  // Fibonacci taps 64,63,61,60 expressed as a mask over bits 63,62,60,59.
  localparam logic [63:0] LfsrTaps = 64'hD800_0000_0000_0000;

  localparam logic [63:0] DefaultLfsrSeed = 64'h5A5A_C3C3_0F0F_9696;

endpackage

// File: rtl/prim_dom_rand_gen_if.sv
// Entropy and randomness handshake bundle between the generator and its environment.
// Signal names follow the generator's point of view.
interface prim_dom_rand_gen_if #(
  parameter int unsigned DW       = 64,
  parameter int unsigned EntropyW = 32
);

  logic                entropy_req_o;
  logic                entropy_ack_i;
  logic [EntropyW-1:0] entropy_i;
  logic                reseed_req_i;
  logic                rand_req_i;
  logic                rand_valid_o;
  logic [DW-1:0]       rand0_o;
  logic [DW-1:0]       rand1_o;
  logic                seeded_o;

  modport master (
    output entropy_req_o, rand_valid_o, rand0_o, rand1_o, seeded_o,
    input  entropy_ack_i, entropy_i, reseed_req_i, rand_req_i
  );

  modport slave (
    input  entropy_req_o, rand_valid_o, rand0_o, rand1_o, seeded_o,
    output entropy_ack_i, entropy_i, reseed_req_i, rand_req_i
  );

endinterface

// File: rtl/prim_dom_rand_lfsr.sv
// 64-bit Fibonacci LFSR with entropy shift-in, per-cycle step and all-zero seed substitution.
module prim_dom_rand_lfsr
  import prim_dom_rand_pkg::*;
#(
  parameter int unsigned EntropyW = 32,
  parameter logic [63:0] LfsrSeed = DefaultLfsrSeed
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                shift_in,
  input  logic                finalize,
  input  logic                step,
  input  logic [EntropyW-1:0] entropy,
  output logic [63:0]         state
);

  logic [63:0] state_q;
  logic [63:0] state_d;
  logic [63:0] shifted;

  if (EntropyW == 64) begin : gen_full_word
    assign shifted = entropy;
  end else begin : gen_part_word
    assign shifted = {state_q[63-EntropyW:0], entropy};
  end

  // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (shift_in) begin
      // An all-zero LFSR would lock up forever, so the last word of a seed may not leave it zero.
      state_d = (finalize && (shifted == '0)) ? LfsrSeed : shifted;
    end else if (step) begin
      state_d = {state_q[62:0], ^(state_q & LfsrTaps)};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= LfsrSeed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/prim_dom_rand_gen.sv
// Fresh-randomness producer for DOM gadgets: seeds an LFSR from entropy, serves masking words on
// request and reseeds after a fixed number of deliveries or on demand.
module prim_dom_rand_gen
  import prim_dom_rand_pkg::*;
#(
  parameter int unsigned DW             = 64,
  parameter int unsigned EntropyW       = 32,
  parameter int unsigned ReseedInterval = 256,
  parameter logic [63:0] LfsrSeed       = DefaultLfsrSeed
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  prim_dom_rand_gen_if.master bus
);

  localparam int unsigned NumWords  = 64 / EntropyW;
  localparam int unsigned WordCntW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned ServeCntW = $clog2(ReseedInterval + 1);

  localparam logic [WordCntW-1:0]  LastWord = WordCntW'(NumWords - 1);
  localparam logic [ServeCntW-1:0] ServeMax = ServeCntW'(ReseedInterval);

  if (DW < 1 || DW > 64) begin : gen_dw_check
    $error("prim_dom_rand_gen: DW must lie in 1..64");
  end
  if (EntropyW < 1 || EntropyW > 64 || (64 % EntropyW) != 0) begin : gen_entropy_w_check
    $error("prim_dom_rand_gen: EntropyW must divide 64");
  end
  if (ReseedInterval < 1) begin : gen_interval_check
    $error("prim_dom_rand_gen: ReseedInterval must be at least 1");
  end

  state_e               state_q, state_d;
  logic [WordCntW-1:0]  word_cnt_q, word_cnt_d;
  logic [ServeCntW-1:0] serve_cnt_q, serve_cnt_d, serve_cnt_inc;
  logic                 pending_q, pending_d;
  logic                 rand_valid_q;
  logic [DW-1:0]        rand0_q, rand1_q;
  logic [63:0]          lfsr;

  logic in_seed, in_ready, accept, last_word, serve, trigger;

  assign in_seed   = (state_q == StSeed);
  assign in_ready  = (state_q == StReady);
  assign accept    = in_seed && bus.entropy_ack_i;
  assign last_word = accept && (word_cnt_q == LastWord);
  assign serve     = in_ready && (bus.rand_req_i || pending_q);

  // The count includes this cycle's serve, so the Nth delivery itself triggers the reseed.
  assign serve_cnt_inc = serve_cnt_q + ServeCntW'(serve);
  assign trigger       = in_ready && (bus.reseed_req_i || (serve_cnt_inc == ServeMax));

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    serve_cnt_d = serve_cnt_q;
    pending_d   = pending_q;

    case (state_q)
      StIdle: state_d = StSeed;
      StSeed: begin
        if (last_word) begin
          word_cnt_d = '0;
          state_d    = StReady;
        end else if (accept) begin
          word_cnt_d = word_cnt_q + WordCntW'(1);
        end
      end
      StReady: begin
        serve_cnt_d = serve_cnt_inc;
        if (trigger) begin
          serve_cnt_d = '0;
          state_d     = StSeed;
        end
      end
      default: begin
        state_d     = StIdle;
        word_cnt_d  = '0;
        serve_cnt_d = '0;
      end
    endcase

    // Requests arriving before the generator is ready collapse into a single pending serve.
    if (serve) begin
      pending_d = 1'b0;
    end else if (bus.rand_req_i && !in_ready) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      word_cnt_q   <= '0;
      serve_cnt_q  <= '0;
      pending_q    <= 1'b0;
      rand_valid_q <= 1'b0;
      rand0_q      <= '0;
      rand1_q      <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      serve_cnt_q  <= serve_cnt_d;
      pending_q    <= pending_d;
      rand_valid_q <= serve;
      // Each share domain gets its own flop bank so the two masks never share a register.
      if (serve) begin
        rand0_q <= lfsr[DW-1:0];
        rand1_q <= lfsr[DW-1:0];
      end
    end
  end

  prim_dom_rand_lfsr #(
    .EntropyW (EntropyW),
    .LfsrSeed (LfsrSeed)
  ) u_lfsr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .shift_in (accept),
    .finalize (last_word),
    .step     (in_ready),
    .entropy  (bus.entropy_i),
    .state    (lfsr)
  );

  assign bus.entropy_req_o = in_seed;
  assign bus.seeded_o      = in_ready;
  assign bus.rand_valid_o  = rand_valid_q;
  assign bus.rand0_o       = rand0_q;
  assign bus.rand1_o       = rand1_q;

  shares_equal_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rand0_q == rand1_q);

  valid_needs_serves_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rand_valid_q && $past(rand_valid_q)) |-> ($past(serve) && $past(serve, 2)));

endmodule

// File: tb/tb_prim_dom_rand_gen.sv
// Self-checking bench for prim_dom_rand_gen: directed vector table, a hand-written stall sequence
// and a randomized run against a word-queue reference model.
module tb_prim_dom_rand_gen;

  localparam int unsigned DW   = 64;
  localparam int unsigned EW   = 32;
  localparam int unsigned INTV = 4;
  localparam logic [63:0] SEED = 64'h5A5A_C3C3_0F0F_9696;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prim_dom_rand_gen_if #(.DW(DW), .EntropyW(EW)) bus ();

  prim_dom_rand_gen #(
    .DW             (DW),
    .EntropyW       (EW),
    .ReseedInterval (INTV),
    .LfsrSeed       (SEED)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic [31:0] ent;
    logic        reseed;
    logic        req;
    logic        ereq;
    logic        seeded;
    logic        valid;
    logic [63:0] rnd;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: phase 0 = waiting, 1 = collecting entropy, 2 = serving.
  int          m_phase;
  logic [31:0] m_words[$];
  logic [63:0] m_lfsr;
  int          m_served;
  logic        m_pend;
  logic        m_valid;
  logic [63:0] m_rand;

  function automatic logic [63:0] nxt(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic void add(input logic r, input logic ack, input logic [31:0] ent,
                              input logic reseed, input logic req, input logic ereq,
                              input logic seeded, input logic valid, input logic [63:0] rnd);
    vec_t v;
    v.rst_n = r; v.ack = ack; v.ent = ent; v.reseed = reseed; v.req = req;
    v.ereq = ereq; v.seeded = seeded; v.valid = valid; v.rnd = rnd;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic ack, input logic [31:0] ent,
                       input logic reseed, input logic req);
    rst_n             = r;
    bus.entropy_ack_i = ack;
    bus.entropy_i     = ent;
    bus.reseed_req_i  = reseed;
    bus.rand_req_i    = req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic ereq, input logic seeded,
                               input logic valid, input logic [63:0] rnd);
    check({tag, " entropy_req"}, 64'(bus.entropy_req_o), 64'(ereq));
    check({tag, " seeded"},      64'(bus.seeded_o),      64'(seeded));
    check({tag, " rand_valid"},  64'(bus.rand_valid_o),  64'(valid));
    check({tag, " rand0"},       bus.rand0_o,            rnd);
    check({tag, " rand1"},       bus.rand1_o,            rnd);
  endtask

  task automatic model_step(input logic r, input logic ack, input logic [31:0] ent,
                            input logic reseed, input logic req);
    int ph;
    if (!r) begin
      m_phase = 0; m_lfsr = SEED; m_words.delete(); m_served = 0;
      m_pend = 1'b0; m_valid = 1'b0; m_rand = '0;
      return;
    end
    ph      = m_phase;
    m_valid = 1'b0;
    if (ph == 0) begin
      m_phase = 1;
    end else if (ph == 1) begin
      if (ack) begin
        m_words.push_back(ent);
        if (m_words.size() == 64 / EW) begin
          m_lfsr = {m_words[0], m_words[1]};
          if (m_lfsr == 64'd0) m_lfsr = SEED;
          m_words.delete();
          m_phase = 2;
        end
      end
    end else begin
      if (req || m_pend) begin
        m_rand = m_lfsr; m_valid = 1'b1; m_pend = 1'b0; m_served++;
      end
      if (reseed || m_served == INTV) begin
        m_served = 0; m_phase = 1;
      end
      m_lfsr = nxt(m_lfsr);
    end
    if (req && ph != 2) m_pend = 1'b1;
  endtask

  initial begin
    logic [63:0] k, s, t, u;
    logic [31:0] c1, c2, d1, d2, e1, e2, e3, f1, f2;

    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Cold start and the DEADBEEF seed.
    k = 64'hDEAD_BEEF_0123_4567;
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0);
    add(1, 1, 32'h0123_4567, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, k);
    add(1, 0, 0, 0, 0, 0, 1, 0, k);

    // All-zero seed falls back to the default seed.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, SEED);
    add(1, 0, 0, 0, 0, 0, 1, 0, SEED);

    // Interval of 4 serves, then a held (collapsed) request across the reseed.
    c1 = 32'h1357_9BDF; c2 = 32'h2468_ACE0; s = {c1, c2};
    d1 = 32'hCAFE_F00D; d2 = 32'h8BAD_F00D; t = {d1, d2};
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, c1, 0, 0, 1, 0, 0, 0);
    add(1, 1, c2, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, s);
    add(1, 0, 0, 0, 1, 0, 1, 1, nxt(s));
    add(1, 0, 0, 0, 1, 0, 1, 1, nxt(nxt(s)));
    add(1, 0, 0, 0, 1, 1, 0, 1, nxt(nxt(nxt(s))));
    add(1, 0, 0, 0, 1, 1, 0, 0, nxt(nxt(nxt(s))));
    add(1, 1, d1, 0, 1, 1, 0, 0, nxt(nxt(nxt(s))));
    add(1, 1, d2, 0, 0, 0, 1, 0, nxt(nxt(nxt(s))));
    add(1, 0, 0, 0, 0, 0, 1, 1, t);
    add(1, 0, 0, 0, 0, 0, 1, 0, t);

    // Reseed and request in the same ready cycle: the serve still completes.
    u = nxt(nxt(t));
    add(1, 0, 0, 1, 1, 1, 0, 1, u);
    add(1, 0, 0, 0, 0, 1, 0, 0, u);

    // Reset after the first entropy word: two fresh words are required again.
    e1 = 32'h0BAD_CAFE; e2 = 32'hFEED_FACE; e3 = 32'h7777_1111;
    add(1, 1, e1, 0, 0, 1, 0, 0, u);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, e2, 0, 0, 1, 0, 0, 0);
    add(1, 1, e3, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 1, {e2, e3});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].ack, vecs[i].ent, vecs[i].reseed, vecs[i].req);
      tick();
      check_outputs($sformatf("row%0d", i), vecs[i].ereq, vecs[i].seeded, vecs[i].valid,
                    vecs[i].rnd);
    end

    // Entropy stalled for 10 cycles; stray reseed pulses must be ignored meanwhile.
    f1 = 32'hA5A5_0001; f2 = 32'h5A5A_0002;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    check_outputs("stall reset", 1'b0, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
    tick();
    check_outputs("stall start", 1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      tick();
      check_outputs($sformatf("stall%0d", i), 1'b1, 1'b0, 1'b0, 64'd0);
    end
    drive(1'b1, 1'b1, f1, 1'b0, 1'b0);
    tick();
    check_outputs("stall w1", 1'b1, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 1'b1, f2, 1'b0, 1'b0);
    tick();
    check_outputs("stall w2", 1'b0, 1'b1, 1'b0, 64'd0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    tick();
    check_outputs("stall serve", 1'b0, 1'b1, 1'b1, {f1, f2});

    // Randomized run against the reference model, including occasional resets.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    model_step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3000; i++) begin
      logic r, a, rs, rq;
      logic [31:0] e;
      r  = ($urandom_range(0, 199) != 0);
      a  = 1'($urandom_range(0, 1));
      e  = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      rs = ($urandom_range(0, 15) == 0);
      rq = ($urandom_range(0, 2) != 0);
      drive(r, a, e, rs, rq);
      model_step(r, a, e, rs, rq);
      tick();
      check_outputs($sformatf("rand%0d", i), m_phase == 1, m_phase == 2, m_valid, m_rand);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
